j101_wbck: RTL and testbench
============================

J101_WBCK -- requirements
Module: j101_wbck

Interface
REQ-001 SHALL have parameter XLEN, default `J101_XLEN (32), data width.
REQ-002 SHALL have parameter RFIDX_WIDTH, default `J101_RFIDX_WIDTH (5), register index width.
REQ-003 SHALL have parameter STARVE_MAX, default 3, the number of consecutive lost ALU conflicts before ALU is forced.
REQ-004 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port alu_wbck_valid  input  1  ALU result pending.
REQ-007 Port alu_wbck_ready  output  1  ALU result accepted this cycle.
REQ-008 Port alu_wbck_idx  input  RFIDX_WIDTH  ALU destination register.
REQ-009 Port alu_wbck_dat  input  XLEN  ALU result.
REQ-010 Port lsu_wbck_valid  input  1  load result pending.
REQ-011 Port lsu_wbck_ready  output  1  load result accepted this cycle.
REQ-012 Port lsu_wbck_idx  input  RFIDX_WIDTH  load destination register.
REQ-013 Port lsu_wbck_dat  input  XLEN  load data.
REQ-014 Port wbck_wen  output  1  regfile write enable (drives wbck_dest_wen).
REQ-015 Port wbck_idx  output  RFIDX_WIDTH  regfile write index.
REQ-016 Port wbck_dat  output  XLEN  regfile write data.

Function
REQ-017 A source handshake SHALL complete in a cycle where its valid and ready are both 1; at most one handshake SHALL complete per cycle.
REQ-018 Ready SHALL be combinational from the valids and the starvation counter; ready SHALL be 0 for a source whose valid is 0.
REQ-019 With only one valid, that source SHALL be granted.
REQ-020 With both valid, LSU SHALL be granted unless starve_cnt == STARVE_MAX, in which case ALU SHALL be granted.
REQ-021 starve_cnt SHALL increment (saturating at STARVE_MAX) in a cycle where both are valid and LSU is granted; it SHALL clear when ALU is granted or alu_wbck_valid is 0.
REQ-022 The granted idx/dat SHALL be registered; wbck_wen/idx/dat SHALL appear exactly 1 cycle after the handshake, with wbck_wen high for that one cycle.
REQ-023 A granted handshake with idx == 0 SHALL complete normally but SHALL leave wbck_wen at 0 the next cycle (x0 write suppression).
REQ-024 With no handshake, wbck_wen SHALL be 0 the next cycle; wbck_idx/wbck_dat SHALL hold their previous values.
REQ-025 Back-to-back handshakes SHALL produce back-to-back writes with no bubble; the output stage never stalls.
REQ-026 Valid held without grant SHALL keep its idx/dat stable; the block SHALL not check this.

Reset
REQ-027 While rst is 1 at a clock edge: wbck_wen, wbck_idx, wbck_dat, and starve_cnt SHALL become 0.
REQ-028 While rst is 1, alu_wbck_ready and lsu_wbck_ready SHALL be 0 and no handshake SHALL complete.
REQ-029 A handshake in the cycle rst asserts SHALL be dropped; the first write after deassertion SHALL come from a handshake in the first cycle with rst low.

Structure
REQ-030 XLEN/RFIDX defaults SHALL come from the shared j101_defines.v macros; STARVE_MAX SHALL stay local.
REQ-031 Output and counter flops SHALL use one shared sub-module, j101_gnrl_dfflr (load-enable flop with synchronous reset).
REQ-032 j101_wbck SHALL connect directly to the regfile write port; there SHALL be no glue logic in between.

Verification
REQ-033 Reset: rst=1 for 2 cycles with both valids high -> readies 0, wbck_wen=0, wbck_idx=0, wbck_dat=0.
REQ-034 Single ALU: alu idx=5, dat=0xDEADBEEF valid for 1 cycle -> alu ready=1 that cycle; next cycle wen=1, idx=5, dat=0xDEADBEEF; then wen=0.
REQ-035 Conflict: both valid (LSU idx=3 dat=0x11, ALU idx=4 dat=0x22) -> LSU granted; next cycle idx=3 written; ALU held.
REQ-036 Starvation: both valid continuously with fresh LSU data -> LSU granted 3 cycles, ALU granted on cycle 4; starve_cnt back to 0.
REQ-037 x0 suppression: ALU idx=0, dat=0xFFFFFFFF -> ready=1, next cycle wen=0.
REQ-038 Reset mid-stream: LSU handshake in the same cycle rst rises -> no write occurs; starve_cnt=0 after reset.

Source files
------------

// File: rtl/j101_wbck_pkg.sv
//============================================================================
// Module      : j101_wbck_pkg
// Description : Shared types and defaults for the j101 write-back arbiter.
//               Provides the J101_XLEN / J101_RFIDX_WIDTH defaults when the
//               shared j101_defines.v has not already been compiled, plus
//               the grant encoding used by the arbiter.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

// Fallback values only; a previously compiled j101_defines.v takes precedence.
`ifndef J101_XLEN
`define J101_XLEN 32
`endif
`ifndef J101_RFIDX_WIDTH
`define J101_RFIDX_WIDTH 5
`endif

package j101_wbck_pkg;

    // Which source owns the regfile write port this cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_LSU  = 2'd2
    } wbck_gnt_e;

    // Width needed to count 0..max inclusive, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/j101_gnrl_dfflr.sv
//============================================================================
// Module      : j101_gnrl_dfflr
// Description : General load-enable flop with synchronous active-high reset.
// Ports       : clk   - clock
//               rst   - synchronous reset, clears qout
//               lden  - load enable
//               dnxt  - next value, captured when lden is high
//               qout  - registered value
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module j101_gnrl_dfflr #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    logic [DW-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (lden) begin
            data_q <= dnxt;
        end
    end

    assign qout = data_q;

endmodule

`default_nettype wire

// File: rtl/j101_wbck.sv
//============================================================================
// Module      : j101_wbck
// Description : Write-back arbiter between the ALU and LSU result paths and
//               the single regfile write port. LSU wins conflicts unless the
//               ALU has lost STARVE_MAX conflicts in a row. The winner's
//               idx/dat are registered and presented one cycle later; writes
//               to x0 are accepted but never enabled.
// Ports       : clk, rst                       - clock, sync active-high reset
//               alu_wbck_valid/ready/idx/dat   - ALU result handshake
//               lsu_wbck_valid/ready/idx/dat   - load result handshake
//               wbck_wen/idx/dat               - regfile write port
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module j101_wbck
    import j101_wbck_pkg::*;
#(
    parameter int XLEN        = `J101_XLEN,
    parameter int RFIDX_WIDTH = `J101_RFIDX_WIDTH,
    parameter int STARVE_MAX  = 3
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   alu_wbck_valid,
    output logic                   alu_wbck_ready,
    input  logic [RFIDX_WIDTH-1:0] alu_wbck_idx,
    input  logic [XLEN-1:0]        alu_wbck_dat,

    input  logic                   lsu_wbck_valid,
    output logic                   lsu_wbck_ready,
    input  logic [RFIDX_WIDTH-1:0] lsu_wbck_idx,
    input  logic [XLEN-1:0]        lsu_wbck_dat,

    output logic                   wbck_wen,
    output logic [RFIDX_WIDTH-1:0] wbck_idx,
    output logic [XLEN-1:0]        wbck_dat
);

    localparam int CNT_W = cnt_width(STARVE_MAX);

    wbck_gnt_e              gnt;
    logic                   force_alu;
    logic                   hs;
    logic [RFIDX_WIDTH-1:0] sel_idx;
    logic [XLEN-1:0]        sel_dat;
    logic                   wen_d;
    logic                   wen_q;
    logic [CNT_W-1:0]       starve_d;
    logic [CNT_W-1:0]       starve_q;

    assign force_alu = (starve_q == CNT_W'(STARVE_MAX));

    // Grant decision. Reset blocks both sources so nothing is accepted in a
    // cycle that is about to be wiped.
    always_comb begin
        gnt = GNT_NONE;
        if (!rst) begin
            if (alu_wbck_valid && lsu_wbck_valid) begin
                gnt = force_alu ? GNT_ALU : GNT_LSU;
            end else if (alu_wbck_valid) begin
                gnt = GNT_ALU;
            end else if (lsu_wbck_valid) begin
                gnt = GNT_LSU;
            end
        end
    end

    assign alu_wbck_ready = (gnt == GNT_ALU);
    assign lsu_wbck_ready = (gnt == GNT_LSU);
    assign hs             = alu_wbck_ready | lsu_wbck_ready;

    always_comb begin
        sel_idx = lsu_wbck_idx;
        sel_dat = lsu_wbck_dat;
        if (gnt == GNT_ALU) begin
            sel_idx = alu_wbck_idx;
            sel_dat = alu_wbck_dat;
        end
    end

    // x0 writes complete the handshake but never raise the enable.
    assign wen_d = hs & (sel_idx != '0);

    // Starvation counter: counts only conflicts the ALU lost; any cycle where
    // the ALU is idle or wins restarts the count.
    always_comb begin
        starve_d = starve_q;
        if (!alu_wbck_valid || alu_wbck_ready) begin
            starve_d = '0;
        end else if (lsu_wbck_ready && !force_alu) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    j101_gnrl_dfflr #(.DW(1)) u_wen_dff (
        .clk  (clk),
        .rst  (rst),
        .lden (1'b1),
        .dnxt (wen_d),
        .qout (wen_q)
    );

    // idx/dat only load on a handshake so they hold between writes.
    j101_gnrl_dfflr #(.DW(RFIDX_WIDTH)) u_idx_dff (
        .clk  (clk),
        .rst  (rst),
        .lden (hs),
        .dnxt (sel_idx),
        .qout (wbck_idx)
    );

    j101_gnrl_dfflr #(.DW(XLEN)) u_dat_dff (
        .clk  (clk),
        .rst  (rst),
        .lden (hs),
        .dnxt (sel_dat),
        .qout (wbck_dat)
    );

    j101_gnrl_dfflr #(.DW(CNT_W)) u_starve_dff (
        .clk  (clk),
        .rst  (rst),
        .lden (1'b1),
        .dnxt (starve_d),
        .qout (starve_q)
    );

    assign wbck_wen = wen_q;

endmodule

`default_nettype wire

// File: tb/tb_j101_wbck.sv
//============================================================================
// Module      : tb_j101_wbck
// Description : Directed self-checking bench for j101_wbck. A reference model
//               predicts readies and the next-cycle regfile write; predicted
//               writes go through a queue and are compared after the edge.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_j101_wbck;

    localparam int XLEN   = 32;
    localparam int IDX_W  = 5;
    localparam int SMAX   = 3;

    typedef struct {
        logic             wen;
        logic [IDX_W-1:0] idx;
        logic [XLEN-1:0]  dat;
    } wr_t;

    logic             clk;
    logic             rst;
    logic             alu_wbck_valid;
    logic             alu_wbck_ready;
    logic [IDX_W-1:0] alu_wbck_idx;
    logic [XLEN-1:0]  alu_wbck_dat;
    logic             lsu_wbck_valid;
    logic             lsu_wbck_ready;
    logic [IDX_W-1:0] lsu_wbck_idx;
    logic [XLEN-1:0]  lsu_wbck_dat;
    logic             wbck_wen;
    logic [IDX_W-1:0] wbck_idx;
    logic [XLEN-1:0]  wbck_dat;

    int ntests = 0;
    int nfail  = 0;

    // Reference model state
    int               m_starve = 0;
    logic [IDX_W-1:0] m_idx    = '0;
    logic [XLEN-1:0]  m_dat    = '0;
    wr_t              exp_q[$];

    j101_wbck dut (
        .clk            (clk),
        .rst            (rst),
        .alu_wbck_valid (alu_wbck_valid),
        .alu_wbck_ready (alu_wbck_ready),
        .alu_wbck_idx   (alu_wbck_idx),
        .alu_wbck_dat   (alu_wbck_dat),
        .lsu_wbck_valid (lsu_wbck_valid),
        .lsu_wbck_ready (lsu_wbck_ready),
        .lsu_wbck_idx   (lsu_wbck_idx),
        .lsu_wbck_dat   (lsu_wbck_dat),
        .wbck_wen       (wbck_wen),
        .wbck_idx       (wbck_idx),
        .wbck_dat       (wbck_dat)
    );

    // Starts high so the first falling edge precedes the first rising edge.
    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] got,
                         input logic [XLEN-1:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive, check readies mid-cycle, push the predicted
    // write, then pop and compare it just after the rising edge.
    task automatic step(input string tag, input logic r,
                        input logic av, input logic [IDX_W-1:0] ai,
                        input logic [XLEN-1:0] ad,
                        input logic lv, input logic [IDX_W-1:0] li,
                        input logic [XLEN-1:0] ld);
        logic er_a, er_l;
        wr_t  w, got;
        rst            = r;
        alu_wbck_valid = av;
        alu_wbck_idx   = ai;
        alu_wbck_dat   = ad;
        lsu_wbck_valid = lv;
        lsu_wbck_idx   = li;
        lsu_wbck_dat   = ld;

        er_a = 1'b0;
        er_l = 1'b0;
        if (!r) begin
            if (av && lv) begin
                if (m_starve == SMAX) er_a = 1'b1;
                else                  er_l = 1'b1;
            end else begin
                er_a = av;
                er_l = lv;
            end
        end

        if (r) begin
            m_idx = '0;
            m_dat = '0;
            w.wen = 1'b0;
        end else if (er_a || er_l) begin
            m_idx = er_a ? ai : li;
            m_dat = er_a ? ad : ld;
            w.wen = (m_idx != '0);
        end else begin
            w.wen = 1'b0;
        end
        w.idx = m_idx;
        w.dat = m_dat;
        exp_q.push_back(w);

        if (r || !av || er_a)  m_starve = 0;
        else if (er_l)         m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;

        @(negedge clk);
        check({tag, ".alu_ready"}, XLEN'(alu_wbck_ready), XLEN'(er_a));
        check({tag, ".lsu_ready"}, XLEN'(lsu_wbck_ready), XLEN'(er_l));

        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check({tag, ".wen"}, XLEN'(wbck_wen), XLEN'(got.wen));
        check({tag, ".idx"}, XLEN'(wbck_idx), XLEN'(got.idx));
        check({tag, ".dat"}, wbck_dat, got.dat);
    endtask

    initial begin
        // Reset with both sources requesting
        step("rst0", 1, 1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
        step("rst1", 1, 1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
        step("idle", 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

        // Single ALU write, then idle (wen drops, idx/dat hold)
        step("alu1", 0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0);
        step("alu1_after", 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

        // Conflict: LSU first, held ALU next
        step("conf_lsu", 0, 1, 5'd4, 32'h22, 1, 5'd3, 32'h11);
        step("conf_alu", 0, 1, 5'd4, 32'h22, 0, 5'd0, 32'h0);

        // Starvation: three LSU wins, then ALU forced, then count restarts
        for (int i = 0; i < 8; i++) begin
            step($sformatf("starve%0d", i), 0, 1, 5'd7, 32'hA5A5A5A5,
                 1, IDX_W'(10 + i), 32'h1000 + XLEN'(i));
        end
        step("starve_idle", 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

        // x0 suppression, ALU then LSU
        step("x0_alu", 0, 1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'h0);
        step("x0_lsu", 0, 0, 5'd0, 32'h0, 1, 5'd0, 32'h12345678);
        step("lsu1", 0, 0, 5'd0, 32'h0, 1, 5'd9, 32'hCAFEF00D);
        step("lsu1_after", 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

        // Reset mid-stream: build up starvation, reset during a handshake,
        // then confirm the count restarted from zero.
        step("pre_rst0", 0, 1, 5'd6, 32'h66, 1, 5'd20, 32'h200);
        step("pre_rst1", 0, 1, 5'd6, 32'h66, 1, 5'd21, 32'h201);
        step("mid_rst", 1, 1, 5'd6, 32'h66, 1, 5'd22, 32'h202);
        for (int i = 0; i < 5; i++) begin
            step($sformatf("post_rst%0d", i), 0, 1, 5'd6, 32'h66,
                 1, IDX_W'(23 + i), 32'h300 + XLEN'(i));
        end
        step("end_idle", 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

`default_nettype wire
